// File: rtl/complex_mult_pipe_if.sv
// -----------------------------------------------------------------------------
// complex_mult_pipe_if
//   Sample bus of the pipelined complex multiplier: input handshake and
//   operands on the di_* side, result handshake on the do_* side.
//
//   di_vld / di_rdy      input sample valid / block ready
//   d1_re, d1_im         operand 1, signed integer, D1_W bits
//   d2_re, d2_im         operand 2, signed Q1.(D2_W-1) fraction, D2_W bits
//   conj                 1: multiply by conj(d2)
//   rnd_mode             0: round half to even, 1: floor
//   di_tag               sideband carried with the sample
//   do_vld / do_rdy      output sample valid / downstream ready
//   do_re, do_im         result, signed, D1_W+1 bits
//   do_tag               tag of the output sample
//   do_ovf               1 if either result component was clipped
//
//   master: the side that produces samples and consumes results
//   slave : the multiplier
// -----------------------------------------------------------------------------
interface complex_mult_pipe_if #(
    parameter int D1_W  = 13,
    parameter int D2_W  = 11,
    parameter int TAG_W = 8
) ();
    logic             di_vld;
    logic             di_rdy;
    logic [D1_W-1:0]  d1_re;
    logic [D1_W-1:0]  d1_im;
    logic [D2_W-1:0]  d2_re;
    logic [D2_W-1:0]  d2_im;
    logic             conj;
    logic             rnd_mode;
    logic [TAG_W-1:0] di_tag;
    logic             do_vld;
    logic             do_rdy;
    logic [D1_W:0]    do_re;
    logic [D1_W:0]    do_im;
    logic [TAG_W-1:0] do_tag;
    logic             do_ovf;

    modport master (
        output di_vld, d1_re, d1_im, d2_re, d2_im, conj, rnd_mode, di_tag, do_rdy,
        input  di_rdy, do_vld, do_re, do_im, do_tag, do_ovf
    );

    modport slave (
        input  di_vld, d1_re, d1_im, d2_re, d2_im, conj, rnd_mode, di_tag, do_rdy,
        output di_rdy, do_vld, do_re, do_im, do_tag, do_ovf
    );
endinterface

// File: rtl/complex_mult_pipe.sv
// -----------------------------------------------------------------------------
// complex_mult_pipe
//   Pipelined signed complex multiplier, d1 * d2 or d1 * conj(d2), with
//   valid/ready backpressure, selectable rounding (half-to-even or floor),
//   output saturation with an overflow flag, a sideband tag and a saturating
//   count of clipped samples delivered downstream.
//
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   bus          complex_mult_pipe_if.slave sample bus
//   sat_cnt_clr  synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt      number of clipped samples accepted downstream, saturating
//
//   Structure: full-precision products are formed from the bus inputs and
//   captured into LAT-1 delay stages; rounding and saturation sit in front of
//   the output register, so a sample accepted at edge N is on do_* after edge
//   N+LAT-1. Every stage advances only while en = ~do_vld | do_rdy.
// -----------------------------------------------------------------------------
module complex_mult_pipe #(
    parameter int D1_W  = 13,
    parameter int D2_W  = 11,
    parameter int LAT   = 3,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    complex_mult_pipe_if.slave bus,
    input  logic               sat_cnt_clr,
    output logic [CNT_W-1:0]   sat_cnt
);
    localparam int PW = D1_W + D2_W + 2;   // full product width
    localparam int FR = D2_W - 1;          // fraction bits of d2
    localparam int RW = PW - FR;           // integer part of the product
    localparam int OW = D1_W + 1;          // result width

    localparam logic [FR-1:0]       HALF  = {1'b1, {(FR-1){1'b0}}};
    localparam logic signed [RW:0]  MAX_V = {{(RW+1-D1_W){1'b0}}, {D1_W{1'b1}}};
    localparam logic signed [RW:0]  MIN_V = {{(RW+1-D1_W){1'b1}}, {D1_W{1'b0}}};

    typedef struct packed {
        logic signed [PW-1:0] p_re;
        logic signed [PW-1:0] p_im;
        logic                 trunc;
        logic [TAG_W-1:0]     tag;
    } prod_t;

    typedef struct packed {
        logic [OW-1:0] val;
        logic          ovf;
    } rs_t;

    // Scale by 2^-FR, round, then clip to the OW-bit output range.
    function automatic rs_t round_sat(input logic signed [PW-1:0] p, input logic trunc);
        logic signed [RW-1:0] q;
        logic [FR-1:0]        frac;
        logic                 up;
        logic signed [RW:0]   r;
        rs_t                  res;
        q    = p[PW-1:FR];                 // floor(p / 2^FR)
        frac = p[FR-1:0];
        // Above half rounds up; exactly half goes to the even neighbour.
        up   = ~trunc & ((frac > HALF) | ((frac == HALF) & q[0]));
        r    = {q[RW-1], q} + {{RW{1'b0}}, up};
        res.ovf = (r > MAX_V) | (r < MIN_V);
        if (r > MAX_V)      res.val = MAX_V[OW-1:0];
        else if (r < MIN_V) res.val = MIN_V[OW-1:0];
        else                res.val = r[OW-1:0];
        return res;
    endfunction

    logic en;
    logic do_vld_q, do_vld_d;
    logic do_ovf_q, do_ovf_d;
    logic [OW-1:0]    do_re_q, do_re_d;
    logic [OW-1:0]    do_im_q, do_im_d;
    logic [TAG_W-1:0] do_tag_q, do_tag_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    prod_t in_prod;
    prod_t tail;
    logic  tail_vld;

    assign en         = ~do_vld_q | bus.do_rdy;
    assign bus.di_rdy = en;

    // Full-precision products. Operands are widened to PW first so that
    // -(-1.0) on the conjugated imaginary part stays exact.
    always_comb begin
        logic signed [PW-1:0] a_re, a_im, c, d;
        a_re = PW'($signed(bus.d1_re));
        a_im = PW'($signed(bus.d1_im));
        c    = PW'($signed(bus.d2_re));
        d    = PW'($signed(bus.d2_im));
        if (bus.conj) d = -d;
        in_prod.p_re  = a_re * c - a_im * d;
        in_prod.p_im  = a_re * d + a_im * c;
        in_prod.trunc = bus.rnd_mode;
        in_prod.tag   = bus.di_tag;
    end

    generate
        if (LAT == 1) begin : g_direct
            assign tail_vld = bus.di_vld;
            assign tail     = in_prod;
        end else begin : g_stages
            logic [LAT-2:0] vld_q, vld_d;
            prod_t          stg_q [LAT-1];
            prod_t          stg_d [LAT-1];

            // NOTE: each _d starts from its _q so every path assigns it;
            // an unassigned path in always_comb would infer a latch.
            always_comb begin
                vld_d = vld_q;
                for (int i = 0; i < LAT - 1; i++) stg_d[i] = stg_q[i];
                if (en) begin
                    vld_d[0] = bus.di_vld;
                    stg_d[0] = in_prod;
                    for (int i = 1; i < LAT - 1; i++) begin
                        vld_d[i] = vld_q[i-1];
                        stg_d[i] = stg_q[i-1];
                    end
                end
            end

            // NOTE: flops use non-blocking assignment so every register
            // samples the pre-edge values regardless of statement order.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_q <= '0;
                else     vld_q <= vld_d;
            end

            // NOTE: the data stages carry no reset; only the valid bits
            // decide what is real, so the wide payload stays reset-free.
            always_ff @(posedge clk) begin
                stg_q <= stg_d;
            end

            assign tail_vld = vld_q[LAT-2];
            assign tail     = stg_q[LAT-2];
        end
    endgenerate

    always_comb begin
        rs_t re_rs, im_rs;
        re_rs = round_sat(tail.p_re, tail.trunc);
        im_rs = round_sat(tail.p_im, tail.trunc);

        do_vld_d = do_vld_q;
        do_re_d  = do_re_q;
        do_im_d  = do_im_q;
        do_tag_d = do_tag_q;
        do_ovf_d = do_ovf_q;
        if (en) begin
            do_vld_d = tail_vld;
            if (tail_vld) begin
                do_re_d  = re_rs.val;
                do_im_d  = im_rs.val;
                do_tag_d = tail.tag;
                do_ovf_d = re_rs.ovf | im_rs.ovf;
            end
        end

        // Clear has priority; the counter sticks at all-ones.
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr)
            sat_cnt_d = '0;
        else if (do_vld_q & bus.do_rdy & do_ovf_q & ~(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_vld_q  <= 1'b0;
            do_re_q   <= '0;
            do_im_q   <= '0;
            do_tag_q  <= '0;
            do_ovf_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            do_vld_q  <= do_vld_d;
            do_re_q   <= do_re_d;
            do_im_q   <= do_im_d;
            do_tag_q  <= do_tag_d;
            do_ovf_q  <= do_ovf_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.do_vld = do_vld_q;
    assign bus.do_re  = do_re_q;
    assign bus.do_im  = do_im_q;
    assign bus.do_tag = do_tag_q;
    assign bus.do_ovf = do_ovf_q;
    assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_complex_mult_pipe
//   Bench for complex_mult_pipe with D1_W=13, D2_W=11, LAT=3, TAG_W=8 and a
//   4-bit sat_cnt so its saturation point is reachable. A negedge scoreboard
//   compares every delivered sample against a plain-integer reference model,
//   and directed sequences cover latency, rounding, conjugation, clipping,
//   stalls, reset and the clear/increment priority.
// -----------------------------------------------------------------------------
module tb_complex_mult_pipe;
    localparam int     D1_W    = 13;
    localparam int     D2_W    = 11;
    localparam int     LAT     = 3;
    localparam int     TAG_W   = 8;
    localparam int     CNT_W   = 4;
    localparam longint SCALE   = 1024;
    localparam longint OUT_MAX = 8191;
    localparam longint OUT_MIN = -8192;
    localparam int     CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             sat_cnt_clr;
    logic [CNT_W-1:0] sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    complex_mult_pipe_if #(.D1_W(D1_W), .D2_W(D2_W), .TAG_W(TAG_W)) bus ();

    complex_mult_pipe #(
        .D1_W(D1_W), .D2_W(D2_W), .LAT(LAT), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint           re;
        longint           im;
        logic [TAG_W-1:0] tag;
        bit               ovf;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt = 0;

    function automatic longint scale_round(input longint p, input bit trunc);
        longint fl;
        longint rem;
        fl = p / SCALE;
        if ((p % SCALE) != 0 && p < 0) fl = fl - 1;
        rem = p - fl * SCALE;
        if (trunc) return fl;
        if (rem > SCALE / 2) return fl + 1;
        if (rem == SCALE / 2 && (fl % 2) != 0) return fl + 1;
        return fl;
    endfunction

    function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                   input longint bi, input bit cj, input bit trunc,
                                   input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint d;
        d     = cj ? -bi : bi;
        e.re  = scale_round(ar * br - ai * d, trunc);
        e.im  = scale_round(ar * d + ai * br, trunc);
        e.tag = tag;
        e.ovf = 0;
        if (e.re > OUT_MAX) begin e.re = OUT_MAX; e.ovf = 1; end
        if (e.re < OUT_MIN) begin e.re = OUT_MIN; e.ovf = 1; end
        if (e.im > OUT_MAX) begin e.im = OUT_MAX; e.ovf = 1; end
        if (e.im < OUT_MIN) begin e.im = OUT_MIN; e.ovf = 1; end
        return e;
    endfunction

    // ---------------- scoreboard (samples at negedge) ----------------
    logic             stalled = 1'b0;
    logic [D1_W:0]    held_re, held_im;
    logic [TAG_W-1:0] held_tag;
    logic             held_ovf;
    bit               sb_fire;
    exp_t             sb_e;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            stalled   = 1'b0;
        end else begin
            sb_fire = bus.do_vld && bus.do_rdy;
            check("di_rdy", bus.di_rdy, !bus.do_vld || bus.do_rdy);
            check("sat_cnt", sat_cnt, model_cnt);
            if (stalled) begin
                check("hold_vld", bus.do_vld, 1);
                check("hold_re",  bus.do_re,  held_re);
                check("hold_im",  bus.do_im,  held_im);
                check("hold_tag", bus.do_tag, held_tag);
                check("hold_ovf", bus.do_ovf, held_ovf);
            end
            if (sb_fire) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check("out_re",  $signed(bus.do_re), sb_e.re);
                    check("out_im",  $signed(bus.do_im), sb_e.im);
                    check("out_tag", bus.do_tag, sb_e.tag);
                    check("out_ovf", bus.do_ovf, sb_e.ovf);
                    if (!sat_cnt_clr && sb_e.ovf && model_cnt < CNT_MAX)
                        model_cnt = model_cnt + 1;
                end
            end
            if (sat_cnt_clr) model_cnt = 0;
            if (bus.di_vld && bus.di_rdy)
                exp_q.push_back(model(longint'($signed(bus.d1_re)), longint'($signed(bus.d1_im)),
                                      longint'($signed(bus.d2_re)), longint'($signed(bus.d2_im)),
                                      bus.conj, bus.rnd_mode, bus.di_tag));
            stalled  = bus.do_vld && !bus.do_rdy;
            held_re  = bus.do_re;
            held_im  = bus.do_im;
            held_tag = bus.do_tag;
            held_ovf = bus.do_ovf;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [TAG_W-1:0] tag_ctr = 8'd1;

    task automatic drive(input longint ar, input longint ai, input longint br, input longint bi,
                         input bit cj, input bit trunc, input logic [TAG_W-1:0] tag);
        bus.d1_re    = D1_W'(ar);
        bus.d1_im    = D1_W'(ai);
        bus.d2_re    = D2_W'(br);
        bus.d2_im    = D2_W'(bi);
        bus.conj     = cj;
        bus.rnd_mode = trunc;
        bus.di_tag   = tag;
    endtask

    task automatic drive_rand(input logic [TAG_W-1:0] tag);
        longint ar, ai, br, bi;
        ar = longint'($urandom_range(0, 8191)) - 4096;
        ai = longint'($urandom_range(0, 8191)) - 4096;
        br = longint'($urandom_range(0, 2047)) - 1024;
        bi = longint'($urandom_range(0, 2047)) - 1024;
        if ($urandom_range(0, 5) == 0) ar = -4096;
        if ($urandom_range(0, 5) == 0) ai = -4096;
        if ($urandom_range(0, 5) == 0) br = -1024;
        if ($urandom_range(0, 5) == 0) bi = -1024;
        drive(ar, ai, br, bi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    endtask

    // One sample into an idle pipe with do_rdy=1; checks latency and result.
    // Called and returns at posedge+1.
    task automatic run_one(input string name, input longint ar, input longint ai,
                           input longint br, input longint bi, input bit cj, input bit trunc,
                           input longint er, input longint ei, input bit eo);
        int n;
        logic [TAG_W-1:0] t;
        t = tag_ctr;
        drive(ar, ai, br, bi, cj, trunc, t);
        bus.di_vld = 1'b1;
        bus.do_rdy = 1'b1;
        #1 check({name, "_rdy"}, bus.di_rdy, 1);
        @(posedge clk);
        #1 bus.di_vld = 1'b0;
        n = 0;
        while (bus.do_vld !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check({name, "_lat"}, n, LAT - 1);
        check({name, "_re"},  $signed(bus.do_re), er);
        check({name, "_im"},  $signed(bus.do_im), ei);
        check({name, "_ovf"}, bus.do_ovf, eo);
        check({name, "_tag"}, bus.do_tag, t);
        @(posedge clk);
        #1 tag_ctr++;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        bus.di_vld = 1'b0;
        while (exp_q.size() != 0 && cyc < 200) begin
            bus.do_rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 cyc++;
        end
        bus.do_rdy = 1'b1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, bus.do_vld, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  i, cyc, n;
        bit  acc;

        rst         = 1'b1;
        sat_cnt_clr = 1'b0;
        bus.di_vld  = 1'b0;
        bus.do_rdy  = 1'b0;
        drive(0, 0, 0, 0, 1'b0, 1'b0, '0);
        #12;
        check("rst_do_vld",  bus.do_vld, 0);
        check("rst_do_re",   bus.do_re,  0);
        check("rst_do_im",   bus.do_im,  0);
        check("rst_do_tag",  bus.do_tag, 0);
        check("rst_do_ovf",  bus.do_ovf, 0);
        check("rst_sat_cnt", sat_cnt,    0);
        #10 rst = 1'b0;
        #1 check("rst_di_rdy", bus.di_rdy, 1);
        @(posedge clk);
        #1;

        // Basic product, latency, tag echo.
        run_one("t1", 100, 50, 512, 0, 1'b0, 1'b0, 50, 25, 1'b0);
        // Half-way rounding: round-half-even vs floor.
        run_one("t2_p3_even",  3, 0, 512, 0, 1'b0, 1'b0,  2, 0, 1'b0);
        run_one("t2_p1_even",  1, 0, 512, 0, 1'b0, 1'b0,  0, 0, 1'b0);
        run_one("t2_m1_even", -1, 0, 512, 0, 1'b0, 1'b0,  0, 0, 1'b0);
        run_one("t2_p3_floor", 3, 0, 512, 0, 1'b0, 1'b1,  1, 0, 1'b0);
        run_one("t2_p1_floor", 1, 0, 512, 0, 1'b0, 1'b1,  0, 0, 1'b0);
        run_one("t2_m1_floor",-1, 0, 512, 0, 1'b0, 1'b1, -1, 0, 1'b0);
        // Conjugation.
        run_one("t3_conj",   100, 50, 0, 512, 1'b1, 1'b0,  25, -50, 1'b0);
        run_one("t3_noconj", 100, 50, 0, 512, 1'b0, 1'b0, -25,  50, 1'b0);
        // Full-scale corner clips the imaginary part.
        sat_cnt_clr = 1'b1;
        @(posedge clk);
        #1 sat_cnt_clr = 1'b0;
        check("t4_cnt_before", sat_cnt, 0);
        run_one("t4", -4096, -4096, -1024, -1024, 1'b0, 1'b0, 0, 8191, 1'b1);
        check("t4_cnt_after", sat_cnt, 1);

        // Tags 1..8 back-to-back under random backpressure.
        i   = 1;
        cyc = 0;
        while (i <= 8 && cyc < 200) begin
            drive_rand(TAG_W'(i));
            bus.di_vld = 1'b1;
            bus.do_rdy = 1'($urandom_range(0, 1));
            #1 acc = bus.di_rdy;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        check("t5_sent", i, 9);
        drain("t5");

        // Clipping burst drives sat_cnt to its ceiling.
        drive(-4096, -4096, -1024, -1024, 1'b0, 1'b0, 8'hAA);
        bus.di_vld = 1'b1;
        bus.do_rdy = 1'b1;
        repeat (20) @(posedge clk);
        #1 bus.di_vld = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1 check("sat_cnt_ceiling", sat_cnt, CNT_MAX);

        // Random traffic with random stalls and occasional clears.
        for (int k = 0; k < 400; k++) begin
            drive_rand(TAG_W'($urandom_range(0, 255)));
            bus.di_vld  = ($urandom_range(0, 9) < 7);
            bus.do_rdy  = ($urandom_range(0, 9) < 7);
            sat_cnt_clr = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        sat_cnt_clr = 1'b0;
        drain("rand");

        // Reset mid-cycle with samples in flight.
        drive(-4096, -4096, -1024, -1024, 1'b0, 1'b0, 8'h55);
        bus.di_vld = 1'b1;
        bus.do_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.di_vld = 1'b0;
        check("t6_inflight_vld", bus.do_vld, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_do_vld",  bus.do_vld, 0);
        check("t6_rst_sat_cnt", sat_cnt,    0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_one("t6_after_rst", 100, 50, 512, 0, 1'b0, 1'b0, 50, 25, 1'b0);
        check("t6_no_stale", bus.do_vld, 0);

        // Clear coincident with a clipped sample being accepted downstream.
        run_one("t6_ovf", -4096, -4096, -1024, -1024, 1'b0, 1'b0, 0, 8191, 1'b1);
        drive(-4096, -4096, -1024, -1024, 1'b0, 1'b0, 8'h77);
        bus.di_vld = 1'b1;
        bus.do_rdy = 1'b0;
        @(posedge clk);
        #1 bus.di_vld = 1'b0;
        n = 0;
        while (bus.do_vld !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("t6_clr_pre", sat_cnt, 1);
        check("t6_clr_ovf", bus.do_ovf, 1);
        bus.do_rdy  = 1'b1;
        sat_cnt_clr = 1'b1;
        @(posedge clk);
        #1 sat_cnt_clr = 1'b0;
        check("t6_clr_wins", sat_cnt, 0);
        drain("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
